// File: rtl/bc_pkg.sv
// Shared BC-MAC definitions.
//   bc_state_e : frame accumulator FSM states
//   BC_*       : slice count, yo width, per-beat sum width
//   sat_add    : unsigned saturating add, result {ovf, sum}, width w (< 32)
package bc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } bc_state_e;

  localparam int BC_SLICES     = 4;
  localparam int BC_YO_W       = 5;
  localparam int BC_BEAT_SUM_W = 4;

  // Bit 32 flags saturation; bits [w-1:0] hold the clamped sum.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) sat_add = {1'b1, mx[31:0]};
    else        sat_add = {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/bc_beat_sum.sv
// Weighted sum of the compressor slices of one beat.
//   slices : BC_SLICES x {carry,sum}; bit0 weight 1, bit1 weight 2
//   sum    : total, max 3*BC_SLICES
module bc_beat_sum
  import bc_pkg::*;
(
  input  logic [BC_SLICES-1:0][1:0]   slices,
  output logic [BC_BEAT_SUM_W-1:0]    sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < BC_SLICES; i++)
      sum = sum + BC_BEAT_SUM_W'(slices[i][0]) + BC_BEAT_SUM_W'({slices[i][1], 1'b0});
  end

endmodule

// File: rtl/bc_popcnt_acc.sv
// Frame bit-count accumulator at the tail of the 8:2 compressor chain.
//   in_valid/in_ready/in_last : beat handshake, in_ready depends on state only
//   out0..out3, yo            : compressor slices and chain carry vector
//   res_valid/res_ready       : result handshake
//   res_data/res_ovf/res_beats: frame count, saturation/beat-limit flag, beat count
//   busy                      : frame in progress or result pending
module bc_popcnt_acc
  import bc_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int MAX_BEATS = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [1:0]         out0,
  input  logic [1:0]         out1,
  input  logic [1:0]         out2,
  input  logic [1:0]         out3,
  input  logic [4:0]         yo,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic               res_ovf,
  output logic [7:0]         res_beats,
  output logic               busy
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  bc_state_e              state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [BEAT_W-1:0]      beats_q, beats_d;
  logic [BC_YO_W-1:0]     yo_q, yo_d;
  logic                   ovf_q, ovf_d;
  logic                   res_valid_q, res_valid_d;
  logic [ACC_W-1:0]       res_data_q, res_data_d;
  logic                   res_ovf_q, res_ovf_d;
  logic [7:0]             res_beats_q, res_beats_d;

  logic [BC_BEAT_SUM_W-1:0] beat_sum;
  logic [BC_YO_W-1:0]       resid;
  logic [ACC_W-1:0]         acc_base;
  logic [BEAT_W-1:0]        beats_new;
  logic [32:0]              add_beat, add_res;
  logic                     accept, end_frame, limit_hit;
  logic                     unused_hi;

  bc_beat_sum u_beat_sum (
    .slices ({out3, out2, out1, out0}),
    .sum    (beat_sum)
  );

  // resid = 2 * popcount(yo_q); max 10 fits BC_YO_W bits
  always_comb begin
    resid = '0;
    for (int i = 0; i < BC_YO_W; i++)
      resid = resid + BC_YO_W'({yo_q[i], 1'b0});
  end

  // First beat of a frame starts from zero regardless of leftover state.
  assign acc_base  = (state_q == IDLE) ? '0 : acc_q;
  assign beats_new = ((state_q == IDLE) ? '0 : beats_q) + BEAT_W'(1);
  assign add_beat  = sat_add(32'(acc_base), 32'(beat_sum), ACC_W);
  assign add_res   = sat_add(32'(acc_q), 32'(resid), ACC_W);
  assign unused_hi = ^{add_beat[31:ACC_W], add_res[31:ACC_W]};

  assign in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign accept    = in_valid && in_ready;
  // The beat that reaches MAX_BEATS closes the frame even without in_last.
  assign limit_hit = (beats_new == BEAT_W'(MAX_BEATS)) && !in_last;
  assign end_frame = in_last || limit_hit;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    yo_d        = yo_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_beats_d = res_beats_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = add_beat[ACC_W-1:0];
          beats_d = beats_new;
          ovf_d   = ((state_q == IDLE) ? 1'b0 : ovf_q) | add_beat[32] | limit_hit;
          if (end_frame) begin
            yo_d    = yo;
            state_d = FLUSH;
          end else begin
            state_d = ACC;
          end
        end
      end
      FLUSH: begin
        res_data_d  = add_res[ACC_W-1:0];
        res_ovf_d   = ovf_q | add_res[32];
        res_beats_d = '0;
        res_beats_d[BEAT_W-1:0] = beats_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          acc_d       = '0;
          beats_d     = '0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      yo_q        <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      yo_q        <= yo_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_beats_q <= res_beats_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_beats = res_beats_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bc_popcnt_acc.sv
// Directed bench: dut0 uses default parameters, dut1 uses ACC_W=4, MAX_BEATS=3
// for saturation and beat-limit cases. Data inputs are shared, valid/ready split.
module tb_bc_popcnt_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_last = 1'b0;
  logic [1:0] o0 = '0, o1 = '0, o2 = '0, o3 = '0;
  logic [4:0] yo = '0;
  logic       iv [2];
  logic       rr [2];
  logic       ir [2];
  logic       rv [2];
  logic       ro [2];
  logic       bz [2];
  logic [7:0] rb [2];
  logic [15:0] rd0;
  logic [3:0]  rd1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bc_popcnt_acc u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_last(in_last),
    .out0(o0), .out1(o1), .out2(o2), .out3(o3), .yo(yo),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_data(rd0), .res_ovf(ro[0]),
    .res_beats(rb[0]), .busy(bz[0])
  );

  bc_popcnt_acc #(.ACC_W(4), .MAX_BEATS(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_last(in_last),
    .out0(o0), .out1(o1), .out2(o2), .out3(o3), .yo(yo),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_data(rd1), .res_ovf(ro[1]),
    .res_beats(rb[1]), .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one beat to DUT sel and hold it until accepted (bounded).
  task automatic send(input int sel, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] d,
                      input logic [4:0] y, input logic last);
    int n;
    o0 = a; o1 = b; o2 = c; o3 = d; yo = y; in_last = last;
    iv[sel] = 1'b1;
    n = 0;
    while (!ir[sel] && n < 20) begin
      tick;
      n++;
    end
    if (n == 20) chk("accept_timeout", 0, 1);
    tick;
    iv[sel] = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic handshake(input int sel);
    rr[sel] = 1'b1;
    tick;
    rr[sel] = 1'b0;
  endtask

  initial begin
    iv[0] = 0; iv[1] = 0; rr[0] = 0; rr[1] = 0;
    #12;
    chk("rst_valid", rv[0], 0);
    chk("rst_data", rd0, 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_beats", rb[0], 0);
    rst_n = 1'b1;
    tick;
    chk("idle_ready", ir[0], 1);

    // single beat: 12 + 2*5 = 22
    send(0, 2'b11, 2'b11, 2'b11, 2'b11, 5'b11111, 1'b1);
    chk("t1_flush_valid", rv[0], 0);
    chk("t1_flush_ready", ir[0], 0);
    chk("t1_flush_busy", bz[0], 1);
    tick;
    chk("t1_valid", rv[0], 1);
    chk("t1_data", rd0, 22);
    chk("t1_beats", rb[0], 1);
    chk("t1_ovf", ro[0], 0);

    // backpressure: five cycles held
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", rv[0], 1);
      chk("bp_data", rd0, 22);
      chk("bp_ready", ir[0], 0);
    end
    handshake(0);
    chk("hs_valid", rv[0], 0);
    chk("hs_ready", ir[0], 1);
    chk("hs_busy", bz[0], 0);

    // three beats with an idle gap: 6 + 0 + 4 + 2*2 = 14
    send(0, 2'b01, 2'b00, 2'b10, 2'b11, 5'b11111, 1'b0);
    chk("t2_busy", bz[0], 1);
    tick;
    send(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b11111, 1'b0);
    send(0, 2'b01, 2'b01, 2'b01, 2'b01, 5'b00101, 1'b1);
    tick;
    chk("t2_valid", rv[0], 1);
    chk("t2_data", rd0, 14);
    chk("t2_beats", rb[0], 3);
    chk("t2_ovf", ro[0], 0);
    handshake(0);

    // saturation in 4 bits: 12 + 12 -> 15
    send(1, 2'b11, 2'b11, 2'b11, 2'b11, 5'b11111, 1'b0);
    send(1, 2'b11, 2'b11, 2'b11, 2'b11, 5'b00000, 1'b1);
    tick;
    chk("sat_valid", rv[1], 1);
    chk("sat_data", rd1, 15);
    chk("sat_ovf", ro[1], 1);
    chk("sat_beats", rb[1], 2);
    handshake(1);

    // beat limit 3: 1+1+1 + 2*2 = 7, ovf set; fourth beat is a new frame
    send(1, 2'b01, 2'b00, 2'b00, 2'b00, 5'b11111, 1'b0);
    send(1, 2'b01, 2'b00, 2'b00, 2'b00, 5'b11111, 1'b0);
    send(1, 2'b01, 2'b00, 2'b00, 2'b00, 5'b00011, 1'b0);
    chk("lim_ready", ir[1], 0);
    tick;
    chk("lim_valid", rv[1], 1);
    chk("lim_data", rd1, 7);
    chk("lim_beats", rb[1], 3);
    chk("lim_ovf", ro[1], 1);
    handshake(1);
    send(1, 2'b01, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b1);
    tick;
    chk("lim2_data", rd1, 1);
    chk("lim2_beats", rb[1], 1);
    chk("lim2_ovf", ro[1], 0);

    // reset mid-frame
    send(0, 2'b11, 2'b11, 2'b11, 2'b11, 5'b11111, 1'b0);
    send(0, 2'b11, 2'b11, 2'b11, 2'b11, 5'b11111, 1'b0);
    chk("pre_rst_busy", bz[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bz[0], 0);
    chk("arst_data0", rd0, 0);
    chk("arst_valid1", rv[1], 0);
    chk("arst_data1", rd1, 0);
    chk("arst_beats1", rb[1], 0);
    chk("arst_ready", ir[0], 1);
    #3 rst_n = 1'b1;
    tick;
    send(0, 2'b11, 2'b10, 2'b00, 2'b00, 5'b00000, 1'b1);
    tick;
    chk("post_valid", rv[0], 1);
    chk("post_data", rd0, 5);
    chk("post_beats", rb[0], 1);
    chk("post_ovf", ro[0], 0);
    handshake(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
